// File: rtl/apb_master_driver_engine.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_driver_engine
//  Description : Parametrised APB master. Commands are buffered in a FIFO.
//                Each command runs SETUP then ACCESS (with wait states) and
//                returns exactly one response through a valid/ready port.
//                Optional macro MASTER_DRV_TIMEOUT_EN adds an ACCESS-phase
//                timeout that aborts a stalled transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_driver_engine #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    input  logic [DATA_W/8-1:0]     cmd_strb,
    output logic [NUM_SLAVES-1:0]   psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W-1:0]       paddr,
    output logic [DATA_W-1:0]       pwdata,
    output logic [DATA_W/8-1:0]     pstrb,
    input  logic                    pready,
    input  logic [DATA_W-1:0]       prdata,
    input  logic                    pslverr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
`ifdef MASTER_DRV_TIMEOUT_EN
    localparam int TO_W   = $clog2(TIMEOUT + 1);
`endif

    // Reject parameter sets the FIFO pointers and strobe math cannot support
    generate
        if ((DATA_W % 8 != 0) || (FIFO_DEPTH < 2) ||
            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
            (NUM_SLAVES < 1) || (TIMEOUT < 1)) begin : g_param_check
            $error("apb_master_driver_engine: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 state_q;

    // Command FIFO storage and bookkeeping
    logic [ADDR_W-1:0]      fifo_addr_q  [FIFO_DEPTH];
    logic [DATA_W-1:0]      fifo_wdata_q [FIFO_DEPTH];
    logic [STRB_W-1:0]      fifo_strb_q  [FIFO_DEPTH];
    logic                   fifo_write_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   cmd_ready_q;
    logic                   cmd_ready_d;

    // Registered bus and response outputs
    logic [NUM_SLAVES-1:0]  psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [ADDR_W-1:0]      paddr_q;
    logic [DATA_W-1:0]      pwdata_q;
    logic [STRB_W-1:0]      pstrb_q;
    logic                   bad_q;
    logic                   rsp_valid_q;
    logic [DATA_W-1:0]      rsp_rdata_q;
    logic                   rsp_err_q;
`ifdef MASTER_DRV_TIMEOUT_EN
    logic [TO_W-1:0]        tmo_cnt_q;
    logic                   rsp_timeout_q;
`endif

    // Combinational helpers
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic [ADDR_W-1:0]      w_head_addr;
    logic [DATA_W-1:0]      w_head_wdata;
    logic [STRB_W-1:0]      w_head_strb;
    logic                   w_head_write;
    logic [SEL_W-1:0]       w_idx;
    logic [NUM_SLAVES-1:0]  w_psel_dec;
    logic                   w_idx_ok;
    logic                   w_tmo_hit;
    logic                   w_acc_done;
    logic                   w_rsp_err;
    logic [DATA_W-1:0]      w_rsp_rdata;

    // FIFO control: push on handshake, pop whenever the FSM starts a transfer
    always_comb begin
        w_head_addr  = fifo_addr_q[rd_ptr_q];
        w_head_wdata = fifo_wdata_q[rd_ptr_q];
        w_head_strb  = fifo_strb_q[rd_ptr_q];
        w_head_write = fifo_write_q[rd_ptr_q];
        w_empty      = (count_q == '0);
        w_push       = cmd_valid && cmd_ready_q;
        w_pop        = !w_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
        count_d      = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        // Push is impossible while full, so a slot freed by a pop shows up next cycle
        cmd_ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
    end

    // Slave select decode from the top address bits of the FIFO head
    always_comb begin
        w_idx = '0;
        if (NUM_SLAVES > 1) begin
            w_idx = w_head_addr[ADDR_W-1 -: SEL_W];
        end
        w_psel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_psel_dec[i] = (int'(w_idx) == i);
        end
        w_idx_ok = |w_psel_dec;
    end

    // ACCESS-phase completion: slave ready, unmapped slave, or timeout abort
    always_comb begin
        w_tmo_hit = 1'b0;
`ifdef MASTER_DRV_TIMEOUT_EN
        w_tmo_hit = !bad_q && !pready && (tmo_cnt_q == TO_W'(TIMEOUT - 1));
`endif
        w_acc_done  = bad_q || pready || w_tmo_hit;
        w_rsp_err   = bad_q || w_tmo_hit || pslverr;
        w_rsp_rdata = (bad_q || w_tmo_hit || pwrite_q) ? '0 : prdata;
    end

    // FIFO storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge pclk) begin
        if (w_push) begin
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
            fifo_strb_q[wr_ptr_q]  <= cmd_strb;
            fifo_write_q[wr_ptr_q] <= cmd_write;
        end
    end

    // Transfer FSM with FIFO pointers and registered bus/response outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            bad_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef MASTER_DRV_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_acc_done) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= w_rsp_rdata;
                        rsp_err_q   <= w_rsp_err;
                        state_q     <= S_RESP;
`ifdef MASTER_DRV_TIMEOUT_EN
                        rsp_timeout_q <= w_tmo_hit;
`endif
                    end else begin
`ifdef MASTER_DRV_TIMEOUT_EN
                        tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Starting a transfer (from IDLE or straight out of RESP) loads the bus
            if (w_pop) begin
                psel_q    <= w_psel_dec;
                penable_q <= 1'b0;
                pwrite_q  <= w_head_write;
                paddr_q   <= w_head_addr;
                pwdata_q  <= w_head_wdata;
                pstrb_q   <= w_head_write ? w_head_strb : '0;
                bad_q     <= !w_idx_ok;
                state_q   <= S_SETUP;
`ifdef MASTER_DRV_TIMEOUT_EN
                tmo_cnt_q <= '0;
`endif
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
`ifdef MASTER_DRV_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master_driver_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_driver_engine
//  Description : Self-checking bench for apb_master_driver_engine. A slave
//                responder and a transaction-level reference model predict
//                bus contents, access length and every response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_driver_engine;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NUM_SLAVES = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
`ifdef MASTER_DRV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  pclk = 1'b0;
    logic                  preset = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic                  cmd_write = 1'b0;
    logic [ADDR_W-1:0]     cmd_addr = '0;
    logic [DATA_W-1:0]     cmd_wdata = '0;
    logic [DATA_W/8-1:0]   cmd_strb = '0;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready = 1'b0;
    logic [DATA_W-1:0]     prdata = '0;
    logic                  pslverr = 1'b0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    always #5 pclk = ~pclk;

    apb_master_driver_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );

    // A command plus the slave behaviour the responder will show for it
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    cmd_t cmdq[$];
    rsp_t respq[$];
    cmd_t offer;
    cmd_t cur;
    rsp_t cur_rsp;
    int   cur_len;
    bit   cur_bad;
    logic [NUM_SLAVES-1:0] cur_psel;
    int   k = 0;
    bit   in_xfer = 1'b0;
    logic prev_pen = 1'b0;
    logic [NUM_SLAVES-1:0] prev_psel = '0;
    bit   rsp_hold = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave index lives in the top two address bits; unmapped index selects nobody
    function automatic logic [NUM_SLAVES-1:0] exp_psel(input logic [31:0] a);
        int idx;
        idx = int'(a[31:30]);
        if (idx < NUM_SLAVES) return NUM_SLAVES'(1 << idx);
        return '0;
    endfunction

    function automatic cmd_t mk_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] s, input int wt, input logic [31:0] rd,
                                    input logic e);
        cmd_t c;
        c.write = w; c.addr = a; c.wdata = d; c.strb = s;
        c.waits = wt; c.prdata = rd; c.slverr = e;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        return mk_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
    endfunction

    // Monitor, slave responder and response consumer, evaluated mid-cycle
    always @(negedge pclk) begin
        if (preset) begin
            cmdq.delete();
            respq.delete();
            in_xfer   = 1'b0;
            k         = 0;
            prev_pen  = 1'b0;
            prev_psel = '0;
            pready    = 1'b0;
            pslverr   = 1'b0;
            rsp_ready = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) cmdq.push_back(offer);

            if (penable && !prev_pen) begin
                chk_eq("xfer_expected", 64'(cmdq.size() != 0), 64'd1);
                chk_eq("one_outstanding", 64'(respq.size()), 64'd0);
                if (cmdq.size() != 0) begin
                    cur      = cmdq.pop_front();
                    cur_psel = exp_psel(cur.addr);
                    cur_bad  = (cur_psel == '0);
                    cur_rsp.tmo   = TO_EN && !cur_bad && (cur.waits >= TIMEOUT);
                    cur_len       = cur_bad ? 1 : (cur_rsp.tmo ? TIMEOUT : cur.waits + 1);
                    cur_rsp.err   = cur_bad || cur_rsp.tmo || cur.slverr;
                    cur_rsp.rdata = (cur_bad || cur_rsp.tmo || cur.write) ? 32'd0 : cur.prdata;
                    in_xfer = 1'b1;
                    k       = 0;
                    chk_eq("setup_psel", 64'(prev_psel), 64'(cur_psel));
                    chk_eq("psel", 64'(psel), 64'(cur_psel));
                    chk_eq("paddr", 64'(paddr), 64'(cur.addr));
                    chk_eq("pwrite", 64'(pwrite), 64'(cur.write));
                    chk_eq("pstrb", 64'(pstrb), 64'(cur.write ? cur.strb : 4'd0));
                    if (cur.write) chk_eq("pwdata", 64'(pwdata), 64'(cur.wdata));
                end
            end

            if (penable && in_xfer) begin
                k++;
                chk_eq("psel_hold", 64'(psel), 64'(cur_psel));
            end

            if (!penable && prev_pen && in_xfer) begin
                chk_eq("access_len", 64'(k), 64'(cur_len));
                chk_eq("rsp_after_access", 64'(rsp_valid), 64'd1);
                respq.push_back(cur_rsp);
                in_xfer = 1'b0;
            end

            // Slave drive for the coming edge; noise wherever the master must ignore it
            if (penable && in_xfer && !cur_bad && (k == cur.waits + 1)) begin
                pready  = 1'b1;
                prdata  = cur.prdata;
                pslverr = cur.slverr;
            end else if (penable) begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end else begin
                pready  = 1'($urandom_range(0, 1));
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end

            if (rsp_valid) begin
                if (respq.size() == 0) begin
                    chk_eq("rsp_expected", 64'd0, 64'd1);
                end else begin
                    chk_eq("rsp_rdata", 64'(rsp_rdata), 64'(respq[0].rdata));
                    chk_eq("rsp_err", 64'(rsp_err), 64'(respq[0].err));
                    chk_eq("rsp_timeout", 64'(rsp_timeout), 64'(respq[0].tmo));
                end
                rsp_ready = rsp_hold ? 1'b0 : 1'($urandom_range(0, 1));
                if (rsp_ready && respq.size() != 0) void'(respq.pop_front());
            end else begin
                rsp_ready = rsp_hold ? 1'b0 : 1'($urandom_range(0, 1));
            end

            prev_pen  = penable;
            prev_psel = psel;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic send(input cmd_t c);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        offer     = c;
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        while (!acc && n < 500) begin
            @(negedge pclk);
            acc = cmd_ready;
            n++;
            @(posedge pclk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) chk_eq("cmd_accept", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cmdq.size() != 0 || respq.size() != 0 || in_xfer || rsp_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        chk_eq("drain_done", 64'(n < 3000), 64'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk_eq({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk_eq({pfx, "_psel"}, 64'(psel), 64'd0);
        chk_eq({pfx, "_penable"}, 64'(penable), 64'd0);
        chk_eq({pfx, "_pwrite"}, 64'(pwrite), 64'd0);
        chk_eq({pfx, "_paddr"}, 64'(paddr), 64'd0);
        chk_eq({pfx, "_pwdata"}, 64'(pwdata), 64'd0);
        chk_eq({pfx, "_pstrb"}, 64'(pstrb), 64'd0);
        chk_eq({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk_eq({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk_eq({pfx, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk_eq({pfx, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no_finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        cmd_t c;
        preset = 1'b1;
        tick(3);
        check_reset_outputs("rst");
        preset = 1'b0;
        tick(2);

        // Single write, no wait states, with start-latency check
        c = mk_cmd(1'b1, 32'h4000_0010, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 1'b0);
        send(c);
        chk_eq("lat_psel_early", 64'(psel), 64'd0);
        tick(1);
        chk_eq("lat_psel", 64'(psel), 64'(exp_psel(c.addr)));
        drain();

        // Read with three wait states
        send(mk_cmd(1'b0, 32'h0000_0040, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0));
        drain();

        // Five commands with the response held off: queue fills, nothing new starts
        rsp_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(mk_cmd(1'($urandom_range(0, 1)), {2'b00, 30'($urandom)}, $urandom,
                        4'($urandom_range(0, 15)), i % 3, $urandom, 1'b0));
        end
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick(1);
            n++;
        end
        chk_eq("held_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_eq("full_cmd_ready", 64'(cmd_ready), 64'd0);
            chk_eq("held_no_setup", 64'(penable), 64'd0);
        end
        rsp_hold = 1'b0;
        drain();

        // Slave error followed by a clean transfer
        send(mk_cmd(1'b0, 32'h8000_0008, 32'h0, 4'h3, 1, 32'h0BAD_F00D, 1'b1));
        send(mk_cmd(1'b1, 32'h4000_0020, 32'h1234_5678, 4'h5, 2, 32'h0, 1'b0));
        drain();

        // Unmapped slave index: completes in one ACCESS cycle with pready held low
        send(mk_cmd(1'b0, 32'hC000_0000, 32'h0, 4'hF, 6, 32'hFFFF_FFFF, 1'b0));
        send(mk_cmd(1'b1, 32'hFFFF_FFFC, 32'hCAFE_0001, 4'h9, 0, 32'h0, 1'b0));
        drain();

        // Reset mid-ACCESS with two commands still queued
        send(mk_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, 12, 32'h5555_AAAA, 1'b0));
        send(mk_cmd(1'b1, 32'h4000_0104, 32'h7777_7777, 4'hF, 0, 32'h0, 1'b0));
        send(mk_cmd(1'b1, 32'h8000_0108, 32'h8888_8888, 4'hF, 0, 32'h0, 1'b0));
        n = 0;
        while (!penable && n < 20) begin
            tick(1);
            n++;
        end
        chk_eq("pre_reset_access", 64'(penable), 64'd1);
        preset = 1'b1;
        tick(1);
        preset = 1'b0;
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk_eq("post_reset_idle_penable", 64'(penable), 64'd0);
            chk_eq("post_reset_idle_psel", 64'(psel), 64'd0);
        end

`ifdef MASTER_DRV_TIMEOUT_EN
        // Stuck slave aborts; one wait fewer than the limit completes normally
        send(mk_cmd(1'b0, 32'h0000_0200, 32'h0, 4'hF, 40, 32'h1357_9BDF, 1'b0));
        drain();
        send(mk_cmd(1'b0, 32'h4000_0204, 32'h0, 4'hF, TIMEOUT - 1, 32'h2468_ACE0, 1'b0));
        drain();
`endif

        // Randomized traffic with random gaps and random response back-pressure
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
            send(rand_cmd());
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
